// File: rtl/spi_slave_mem.sv
// SPI mode-0 slave in front of a word-organised memory, with SCLK/CS/MOSI oversampled in clk.
// Optional burst auto-increment across words is enabled by defining SPI_AUTOINC_EN.
module spi_slave_mem #(
    parameter int unsigned MEM_WIDTH  = 32,
    parameter int unsigned MEM_HEIGHT = 1024,
    parameter int unsigned AWIDTH     = 15,
    parameter int unsigned DWIDTH     = 32
) (
    input  logic clk,
    input  logic rst,
    input  logic sclk,
    input  logic cs_n,
    input  logic mosi,
    output logic miso,
    output logic busy,
    output logic wr_done,
    output logic rd_done,
    output logic align_err
);

    localparam int unsigned IW = $clog2(MEM_HEIGHT);
    localparam int unsigned CW = $clog2(DWIDTH + 1);

    typedef enum logic [1:0] {StIdle, StHdr, StData} state_e;

    logic sclk_s1_q, sclk_s2_q, sclk_s3_q;
    logic cs_s1_q, cs_s2_q, cs_s3_q;
    logic mosi_s1_q, mosi_s2_q;

    state_e              state_q, state_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [AWIDTH-1:0]   hdr_q, hdr_d;
    logic                cmd_q, cmd_d;
    logic [IW-1:0]       widx_q, widx_d;
    logic [DWIDTH-2:0]   rx_q, rx_d;
    logic [DWIDTH-1:0]   tx_q, tx_d;
    logic                tx_en_q, tx_en_d;
    logic                done_q, done_d;
    logic                pend_q, pend_d;
    logic                rd_req_q, rd_req_d;
    logic                tx_load_q, tx_load_d;
    logic                wr_commit_q, wr_commit_d;
    logic [IW-1:0]       wr_idx_q, wr_idx_d;
    logic [DWIDTH-1:0]   wdata_q, wdata_d;
    logic                rd_done_q, rd_done_d;
    logic                align_err_q, align_err_d;

    logic [MEM_WIDTH-1:0] mem [MEM_HEIGHT];
    logic [MEM_WIDTH-1:0] rdata_q;

    logic              sclk_rise, sclk_fall, cs_fall;
    logic [AWIDTH:0]   hdr_full;
    logic [DWIDTH-1:0] word_full;
    logic              unused_addr_hi;

    assign sclk_rise = sclk_s2_q & ~sclk_s3_q;
    assign sclk_fall = ~sclk_s2_q & sclk_s3_q;
    assign cs_fall   = ~cs_s2_q & cs_s3_q;
    assign hdr_full  = {hdr_q, mosi_s2_q};
    assign word_full = {rx_q, mosi_s2_q};
    // Address bits above the word index simply alias onto the memory.
    assign unused_addr_hi = ^hdr_full[AWIDTH-1:IW+2];

`ifdef SPI_AUTOINC_EN
    logic [IW-1:0] widx_inc;
    assign widx_inc = (widx_q == IW'(MEM_HEIGHT - 1)) ? '0 : widx_q + 1'b1;
`endif

    // CS synchroniser resets low so a CS already low at reset release never looks like a fall.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sclk_s1_q <= 1'b0;
            sclk_s2_q <= 1'b0;
            sclk_s3_q <= 1'b0;
            cs_s1_q   <= 1'b0;
            cs_s2_q   <= 1'b0;
            cs_s3_q   <= 1'b0;
            mosi_s1_q <= 1'b0;
            mosi_s2_q <= 1'b0;
        end else begin
            sclk_s1_q <= sclk;
            sclk_s2_q <= sclk_s1_q;
            sclk_s3_q <= sclk_s2_q;
            cs_s1_q   <= cs_n;
            cs_s2_q   <= cs_s1_q;
            cs_s3_q   <= cs_s2_q;
            mosi_s1_q <= mosi;
            mosi_s2_q <= mosi_s1_q;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        hdr_d       = hdr_q;
        cmd_d       = cmd_q;
        widx_d      = widx_q;
        rx_d        = rx_q;
        tx_d        = tx_q;
        tx_en_d     = tx_en_q;
        done_d      = done_q;
        pend_d      = pend_q;
        rd_req_d    = 1'b0;
        tx_load_d   = rd_req_q & ~pend_q;
        wr_commit_d = 1'b0;
        wr_idx_d    = wr_idx_q;
        wdata_d     = wdata_q;
        rd_done_d   = 1'b0;
        align_err_d = align_err_q;

        if (tx_load_q) begin
            tx_d = rdata_q;
        end

        unique case (state_q)
            StIdle: begin
                if (cs_fall) begin
                    state_d = StHdr;
                    cnt_d   = '0;
                    hdr_d   = '0;
                    rx_d    = '0;
                    tx_d    = '0;
                    tx_en_d = 1'b0;
                    done_d  = 1'b0;
                    pend_d  = 1'b0;
                end
            end
            StHdr: begin
                if (cs_s2_q) begin
                    state_d = StIdle;
                end else if (sclk_rise) begin
                    hdr_d = hdr_full[AWIDTH-1:0];
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == CW'(AWIDTH)) begin
                        state_d  = StData;
                        cnt_d    = '0;
                        cmd_d    = hdr_full[AWIDTH];
                        widx_d   = hdr_full[IW+1:2];
                        rd_req_d = ~hdr_full[AWIDTH];
                        if (hdr_full[1:0] != 2'b00) begin
                            align_err_d = 1'b1;
                        end
                    end
                end
            end
            StData: begin
                if (cs_s2_q) begin
                    state_d = StIdle;
                end else if (!done_q) begin
                    if (sclk_rise) begin
                        rx_d  = word_full[DWIDTH-2:0];
                        cnt_d = cnt_q + 1'b1;
                        if (cnt_q == CW'(DWIDTH - 1)) begin
                            cnt_d = '0;
                            if (cmd_q) begin
                                wr_commit_d = 1'b1;
                                wr_idx_d    = widx_q;
                                wdata_d     = word_full;
                            end else begin
                                rd_done_d = 1'b1;
                            end
`ifdef SPI_AUTOINC_EN
                            // Prefetch the next word; it is swapped in on the next SCLK fall.
                            widx_d = widx_inc;
                            if (!cmd_q) begin
                                rd_req_d = 1'b1;
                                pend_d   = 1'b1;
                            end
`else
                            done_d = 1'b1;
`endif
                        end
                    end else if (sclk_fall && !cmd_q) begin
                        if (pend_q) begin
                            tx_d   = rdata_q;
                            pend_d = 1'b0;
                        end else if (!tx_en_q) begin
                            tx_en_d = 1'b1;
                        end else begin
                            tx_d = {tx_q[DWIDTH-2:0], 1'b0};
                        end
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            hdr_q       <= '0;
            cmd_q       <= 1'b0;
            widx_q      <= '0;
            rx_q        <= '0;
            tx_q        <= '0;
            tx_en_q     <= 1'b0;
            done_q      <= 1'b0;
            pend_q      <= 1'b0;
            rd_req_q    <= 1'b0;
            tx_load_q   <= 1'b0;
            wr_commit_q <= 1'b0;
            wr_idx_q    <= '0;
            wdata_q     <= '0;
            rd_done_q   <= 1'b0;
            align_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            hdr_q       <= hdr_d;
            cmd_q       <= cmd_d;
            widx_q      <= widx_d;
            rx_q        <= rx_d;
            tx_q        <= tx_d;
            tx_en_q     <= tx_en_d;
            done_q      <= done_d;
            pend_q      <= pend_d;
            rd_req_q    <= rd_req_d;
            tx_load_q   <= tx_load_d;
            wr_commit_q <= wr_commit_d;
            wr_idx_q    <= wr_idx_d;
            wdata_q     <= wdata_d;
            rd_done_q   <= rd_done_d;
            align_err_q <= align_err_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_commit_q) begin
            mem[wr_idx_q] <= wdata_q;
        end
        if (rd_req_q) begin
            rdata_q <= mem[widx_q];
        end
    end

    assign miso      = (state_q == StData) && !cmd_q && tx_en_q && tx_q[DWIDTH-1];
    assign busy      = (state_q != StIdle);
    assign wr_done   = wr_commit_q;
    assign rd_done   = rd_done_q;
    assign align_err = align_err_q;

endmodule

// File: tb/tb_spi_slave_mem.sv
// Scoreboard bench for spi_slave_mem: a bit-banging master queues expected done events and read
// words, and an independent monitor checks them as the slave reports completion.
module tb_spi_slave_mem;

    logic clk, rst, sclk, cs_n, mosi;
    logic miso, busy, wr_done, rd_done, align_err;

    spi_slave_mem dut (
        .clk       (clk),
        .rst       (rst),
        .sclk      (sclk),
        .cs_n      (cs_n),
        .mosi      (mosi),
        .miso      (miso),
        .busy      (busy),
        .wr_done   (wr_done),
        .rd_done   (rd_done),
        .align_err (align_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct packed {
        logic        is_rd;
        logic [31:0] data;
    } ev_t;

    ev_t         exp_q[$];
    ev_t         ev;
    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] mon_sh   = '0;

    // Master-side view of MISO: sampled on every SCLK rise while selected.
    always @(posedge sclk) begin
        if (!cs_n) mon_sh <= {mon_sh[30:0], miso};
    end

    always @(negedge clk) begin
        if (wr_done || rd_done) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_done: wr_done=%0b rd_done=%0b, none expected",
                         wr_done, rd_done);
            end else begin
                ev = exp_q.pop_front();
                if (wr_done == rd_done || ev.is_rd != rd_done) begin
                    n_fail++;
                    $display("FAIL done_kind: wr_done=%0b rd_done=%0b, expected is_rd=%0b",
                             wr_done, rd_done, ev.is_rd);
                end else if (ev.is_rd && mon_sh !== ev.data) begin
                    n_fail++;
                    $display("FAIL rd_data: got %h expected %h", mon_sh, ev.data);
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] expv);
        n_checks++;
        if (got !== expv) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, got, expv);
        end
    endtask

    task automatic half();
        repeat (8) @(negedge clk);
    endtask

    task automatic send_bit(input logic b);
        mosi = b;
        half();
        sclk = 1'b1;
        half();
        sclk = 1'b0;
    endtask

    // stop_bits < 0 sends nwords full words; otherwise only stop_bits data bits.
    task automatic frame(input logic cmd, input logic [14:0] addr, input logic [31:0] w0,
                         input logic [31:0] w1, input logic [31:0] w2, input int nwords,
                         input int stop_bits, input bit rst_mid);
        logic [15:0] hdr;
        logic [31:0] w;
        int          ndata;
        hdr   = {cmd, addr};
        ndata = (stop_bits >= 0) ? stop_bits : nwords * 32;
        @(negedge clk);
        cs_n = 1'b0;
        half();
        for (int i = 15; i >= 0; i--) send_bit(hdr[i]);
        for (int k = 0; k < ndata; k++) begin
            w = (k < 32) ? w0 : ((k < 64) ? w1 : w2);
            send_bit(w[31 - (k % 32)]);
        end
        if (rst_mid) begin
            rst = 1'b1;
            repeat (2) @(posedge clk);
            #1;
            check("rst_miso", {31'd0, miso}, 32'd0);
            check("rst_busy", {31'd0, busy}, 32'd0);
            check("rst_wr_done", {31'd0, wr_done}, 32'd0);
            check("rst_rd_done", {31'd0, rd_done}, 32'd0);
            check("rst_align_err", {31'd0, align_err}, 32'd0);
            @(negedge clk);
            cs_n = 1'b1;
            mosi = 1'b0;
            repeat (2) @(negedge clk);
            rst = 1'b0;
            half();
        end else begin
            half();
            half();
            cs_n = 1'b1;
            mosi = 1'b0;
            repeat (4) @(posedge clk);
            #1;
            check("busy_after_cs_rise", {31'd0, busy}, 32'd0);
            half();
        end
    endtask

    task automatic wr(input logic [14:0] addr, input logic [31:0] data);
        exp_q.push_back('{is_rd: 1'b0, data: 32'd0});
        frame(1'b1, addr, data, 32'd0, 32'd0, 1, -1, 1'b0);
    endtask

    task automatic rd(input logic [14:0] addr, input logic [31:0] expv);
        exp_q.push_back('{is_rd: 1'b1, data: expv});
        frame(1'b0, addr, 32'd0, 32'd0, 32'd0, 1, -1, 1'b0);
    endtask

    initial begin
        rst  = 1'b1;
        cs_n = 1'b1;
        sclk = 1'b0;
        mosi = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("reset_miso", {31'd0, miso}, 32'd0);
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_wr_done", {31'd0, wr_done}, 32'd0);
        check("reset_rd_done", {31'd0, rd_done}, 32'd0);
        check("reset_align_err", {31'd0, align_err}, 32'd0);

        wr(15'h0010, 32'hDEADBEEF);
        rd(15'h0010, 32'hDEADBEEF);
        check("align_after_t1", {31'd0, align_err}, 32'd0);

        wr(15'h7FFC, 32'h12345678);
        rd(15'h7FFC, 32'h12345678);
        wr(15'h0000, 32'hCAFEF00D);
        rd(15'h7FFC, 32'h12345678);
        rd(15'h0000, 32'hCAFEF00D);
        check("align_after_t2", {31'd0, align_err}, 32'd0);

        wr(15'h0021, 32'hA5A5A5A5);
        check("align_set", {31'd0, align_err}, 32'd1);
        rd(15'h0020, 32'hA5A5A5A5);
        rd(15'h0010, 32'hDEADBEEF);
        check("align_sticky", {31'd0, align_err}, 32'd1);

        // Second write aborted after 20 data bits must not commit.
        wr(15'h0040, 32'hFFFFFFFF);
        frame(1'b1, 15'h0040, 32'h00000000, 32'd0, 32'd0, 1, 20, 1'b0);
        rd(15'h0040, 32'hFFFFFFFF);

        // Reset mid-write: no commit, outputs cleared, align_err cleared.
        wr(15'h0080, 32'h13579BDF);
        frame(1'b1, 15'h0080, 32'h2468ACE0, 32'd0, 32'd0, 1, 10, 1'b1);
        rd(15'h0080, 32'h13579BDF);
        check("align_after_rst", {31'd0, align_err}, 32'd0);

`ifdef SPI_AUTOINC_EN
        for (int i = 0; i < 3; i++) exp_q.push_back('{is_rd: 1'b0, data: 32'd0});
        frame(1'b1, 15'h7FF8, 32'h1, 32'h2, 32'h3, 3, -1, 1'b0);
        exp_q.push_back('{is_rd: 1'b1, data: 32'h1});
        exp_q.push_back('{is_rd: 1'b1, data: 32'h2});
        exp_q.push_back('{is_rd: 1'b1, data: 32'h3});
        frame(1'b0, 15'h7FF8, 32'd0, 32'd0, 32'd0, 3, -1, 1'b0);
        rd(15'h7FFC, 32'h2);
        rd(15'h0000, 32'h3);
`endif

        repeat (20) @(negedge clk);
        check("exp_queue_drained", exp_q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
